// File: rtl/fm0_backscatter_encoder.sv
// FM0 backscatter encoder: preamble, data symbols, then a dummy '1' symbol.
// One output level per clock; each half-symbol lasts HALF_PERIOD clocks.
module fm0_backscatter_encoder #(
   parameter int                      HALF_PERIOD   = 4,
   parameter int                      PREAMBLE_LEN  = 12,
   parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_BITS = 12'b110100100011,
   parameter logic                    IDLE_LEVEL    = 1'b0,
   parameter int                      CNT_WIDTH     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic bit_last,
   output logic bit_ready,
   output logic tx_out,
   output logic tx_active,
   output logic sym_strobe,
   output logic done,
   output logic underrun
);

   localparam int IDXW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam logic [CNT_WIDTH-1:0] HLAST = CNT_WIDTH'(HALF_PERIOD - 1);
   localparam logic [IDXW-1:0]      ILAST = IDXW'(PREAMBLE_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DUMMY} state_t;

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] hcnt, hcnt_n;
   logic [IDXW-1:0]      idx, idx_n;
   logic                 half, half_n;
   logic                 sym_lvl, sym_lvl_n;     // first-half level of the current symbol
   logic                 cur_bit, cur_bit_n;
   logic                 cur_last, cur_last_n;
   logic                 aborted, aborted_n;     // frame ended by underrun: no done pulse
   logic                 done_q, done_n;
   logic                 und_q, und_n;
   logic                 hwrap, pre_end, sym_end, in_sym, lvl;

   assign in_sym  = (state == S_DATA) || (state == S_DUMMY);
   assign hwrap   = (hcnt == HLAST);
   assign pre_end = (state == S_PRE) && hwrap && (idx == ILAST);
   assign sym_end = in_sym && hwrap && half;

   // Level of the current clock; second half of a data '0' inverts mid-symbol.
   always_comb begin
      lvl = IDLE_LEVEL;
      case (state)
         S_PRE:   lvl = PREAMBLE_BITS[ILAST - idx];
         S_DATA:  lvl = (half && !cur_bit) ? ~sym_lvl : sym_lvl;
         S_DUMMY: lvl = sym_lvl;
         default: lvl = IDLE_LEVEL;
      endcase
   end

   assign tx_out     = lvl;
   assign tx_active  = (state != S_IDLE);
   assign bit_ready  = pre_end || ((state == S_DATA) && sym_end && !cur_last);
   assign sym_strobe = in_sym && !half && (hcnt == '0);
   assign done       = done_q;
   assign underrun   = und_q;

   // Next-state, counters and symbol loading.
   always_comb begin
      state_n    = state;
      hcnt_n     = hcnt;
      idx_n      = idx;
      half_n     = half;
      sym_lvl_n  = sym_lvl;
      cur_bit_n  = cur_bit;
      cur_last_n = cur_last;
      aborted_n  = aborted;
      done_n     = 1'b0;
      und_n      = 1'b0;
      if (state != S_IDLE) begin
         hcnt_n = hwrap ? '0 : hcnt + CNT_WIDTH'(1);
         if (hwrap) begin
            idx_n  = idx + IDXW'(1);
            half_n = ~half;
         end
      end
      case (state)
         S_IDLE: begin
            // done_q marks the cycle right after a frame; a start there is dropped
            if (start && !done_q) begin
               state_n   = S_PRE;
               hcnt_n    = '0;
               idx_n     = '0;
               aborted_n = 1'b0;
            end
         end
         S_PRE, S_DATA: begin
            if (bit_ready) begin
               // every symbol opens with a boundary inversion
               half_n    = 1'b0;
               sym_lvl_n = ~lvl;
               if (bit_valid) begin
                  state_n    = S_DATA;
                  cur_bit_n  = bit_in;
                  cur_last_n = bit_last;
               end else begin
                  state_n   = S_DUMMY;
                  und_n     = 1'b1;
                  aborted_n = 1'b1;
               end
            end else if (sym_end) begin
               state_n   = S_DUMMY;
               half_n    = 1'b0;
               sym_lvl_n = ~lvl;
            end
         end
         S_DUMMY: begin
            if (sym_end) begin
               state_n = S_IDLE;
               done_n  = ~aborted;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         hcnt     <= '0;
         idx      <= '0;
         half     <= 1'b0;
         sym_lvl  <= 1'b0;
         cur_bit  <= 1'b0;
         cur_last <= 1'b0;
         aborted  <= 1'b0;
         done_q   <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         state    <= state_n;
         hcnt     <= hcnt_n;
         idx      <= idx_n;
         half     <= half_n;
         sym_lvl  <= sym_lvl_n;
         cur_bit  <= cur_bit_n;
         cur_last <= cur_last_n;
         aborted  <= aborted_n;
         done_q   <= done_n;
         und_q    <= und_n;
      end
   end

endmodule

// File: tb/tb_fm0_backscatter_encoder.sv
// Bench for fm0_backscatter_encoder: per-cycle expected waveform built from FM0 rules.
module tb_fm0_backscatter_encoder;

   localparam int HP   = 4;
   localparam int NCYC = 2400;
   localparam int T1 = 10, T2 = 90, T3 = 200, T4 = 280, T5 = 400, T6 = 600;

   logic clk, rst, start, bit_in, bit_valid, bit_last;
   logic bit_ready, tx_out, tx_active, sym_strobe, done, underrun;

   fm0_backscatter_encoder #(.HALF_PERIOD(HP)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_last(bit_last), .bit_ready(bit_ready), .tx_out(tx_out), .tx_active(tx_active),
      .sym_strobe(sym_strobe), .done(done), .underrun(underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit st_rst[NCYC], st_start[NCYC], st_valid[NCYC], st_bit[NCYC], st_last[NCYC];
   bit exp_tx[NCYC], exp_act[NCYC], exp_str[NCYC], exp_rdy[NCYC], exp_done[NCYC], exp_und[NCYC];
   bit cap_tx[NCYC];
   bit fbits[64];
   bit rbits[3][64];
   int rur[3];
   logic [11:0] pre_v;
   int nchk = 0, nfail = 0;
   int cyc = 0;
   bit running = 0;

   task automatic chk(input string nm, input int c, input logic got, input logic exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%0b exp=%0b", nm, c, got, exp);
      end
   endtask

   task automatic put_half(input int t, input bit l);
      for (int k = 0; k < HP; k++) exp_tx[t+k] = l;
   endtask

   // Frame model: list of half-levels from FM0 rules; ur>=0 is the slot with no valid bit.
   task automatic plan_frame(input int t0, input int nbits, input int ur);
      int t, nsent, nslots;
      bit l, b;
      nsent = (ur >= 0) ? ur : nbits;
      st_start[t0] = 1'b1;
      t = t0 + 1;
      l = 1'b0;
      for (int i = 0; i < 12; i++) begin
         l = pre_v[11-i];
         put_half(t, l);
         t += HP;
      end
      for (int j = 0; j <= nsent; j++) begin
         b = (j < nsent) ? fbits[j] : 1'b1;
         exp_str[t] = 1'b1;
         l = ~l;
         put_half(t, l);
         t += HP;
         if (!b) l = ~l;
         put_half(t, l);
         t += HP;
      end
      for (int c = t0 + 1; c < t; c++) exp_act[c] = 1'b1;
      if (ur < 0) exp_done[t] = 1'b1;
      else exp_und[t0 + 1 + 12*HP + 2*HP*ur] = 1'b1;
      nslots = (ur >= 0) ? ur + 1 : nbits;
      for (int k = 0; k < nslots; k++) begin
         int s;
         s = t0 + 12*HP + 2*HP*k;
         exp_rdy[s]  = 1'b1;
         st_valid[s] = (k != ur);
         st_bit[s]   = fbits[k];
         st_last[s]  = (k == nbits - 1);
      end
   endtask

   task automatic clear_exp(input int a, input int b);
      for (int c = a; c <= b; c++) begin
         exp_tx[c] = 0; exp_act[c] = 0; exp_str[c] = 0;
         exp_rdy[c] = 0; exp_done[c] = 0; exp_und[c] = 0;
      end
   endtask

   // FM0 decode of captured output: boundary inversion and bit = (h1 == h2).
   task automatic decode(input int f, input int t0, input int nsent);
      bit prev, h1, h2;
      int s;
      prev = cap_tx[t0 + 12*HP];
      for (int j = 0; j <= nsent; j++) begin
         s  = t0 + 1 + 12*HP + 2*HP*j;
         h1 = cap_tx[s + 1];
         h2 = cap_tx[s + HP + 1];
         chk("boundary_inv", s, h1 != prev, 1'b1);
         if (j < nsent) chk("decode_bit", s, h1 == h2, rbits[f][j]);
         else           chk("dummy_one", s, h1 == h2, 1'b1);
         prev = h2;
      end
   endtask

   // Compare process: every cycle of the run.
   always @(negedge clk) begin
      if (running) begin
         cap_tx[cyc] = tx_out;
         chk("tx_out",     cyc, tx_out,     exp_tx[cyc]);
         chk("tx_active",  cyc, tx_active,  exp_act[cyc]);
         chk("sym_strobe", cyc, sym_strobe, exp_str[cyc]);
         chk("bit_ready",  cyc, bit_ready,  exp_rdy[cyc]);
         chk("done",       cyc, done,       exp_done[cyc]);
         chk("underrun",   cyc, underrun,   exp_und[cyc]);
      end
   end

   initial begin
      pre_v = 12'b110100100011;
      rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
      // random garbage off the load slots must be ignored
      for (int c = 0; c < NCYC; c++) begin
         st_valid[c] = 1'($urandom_range(0, 1));
         st_bit[c]   = 1'($urandom_range(0, 1));
         st_last[c]  = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 3; c++) st_rst[c] = 1'b1;

      fbits[0] = 1'b0;                                       plan_frame(T1, 1, -1);
      fbits[0] = 1'b1; fbits[1] = 1'b1; fbits[2] = 1'b0;     plan_frame(T2, 3, -1);
      fbits[0] = 1'b1;                                       plan_frame(T3, 1, 0);
      fbits[0] = 1'b0;                                       plan_frame(T4, 1, -1);
      st_rst[T4+30] = 1'b1; st_rst[T4+31] = 1'b1;
      clear_exp(T4 + 30, T4 + 80);
      plan_frame(T4 + 40, 1, -1);
      plan_frame(T5, 1, -1);
      st_start[T5+20] = 1'b1; st_start[T5+65] = 1'b1;
      fbits[0] = 1'b1; fbits[1] = 1'b0;                      plan_frame(T5 + 66, 2, -1);
      for (int f = 0; f < 3; f++) begin
         for (int j = 0; j < 64; j++) rbits[f][j] = 1'($urandom_range(0, 1));
         rur[f] = (f == 2) ? int'($urandom_range(1, 63)) : -1;
         fbits = rbits[f];
         plan_frame(T6 + 600*f, 64, rur[f]);
      end

      // hand-computed pins on the model
      chk("pin_pre0",   T1+1,  exp_tx[T1+1],  1'b1);
      chk("pin_pre2",   T1+9,  exp_tx[T1+9],  1'b0);
      chk("pin_pre11",  T1+48, exp_tx[T1+48], 1'b1);
      chk("pin_t1_d0a", T1+49, exp_tx[T1+49], 1'b0);
      chk("pin_t1_d0b", T1+53, exp_tx[T1+53], 1'b1);
      chk("pin_t1_dum", T1+57, exp_tx[T1+57], 1'b0);
      chk("pin_t1_done",T1+65, exp_done[T1+65], 1'b1);
      chk("pin_t1_act", T1+65, exp_act[T1+65], 1'b0);
      chk("pin_t2_b1",  T2+57, exp_tx[T2+57], 1'b1);
      chk("pin_t2_b2a", T2+65, exp_tx[T2+65], 1'b0);
      chk("pin_t2_b2b", T2+69, exp_tx[T2+69], 1'b1);
      chk("pin_t2_dum", T2+73, exp_tx[T2+73], 1'b0);
      chk("pin_t2_rdy", T2+64, exp_rdy[T2+64], 1'b1);
      chk("pin_t3_und", T3+49, exp_und[T3+49], 1'b1);
      chk("pin_t3_act", T3+57, exp_act[T3+57], 1'b0);
      chk("pin_t5_act", T5+67, exp_act[T5+67], 1'b1);

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc       = c;
         rst       = st_rst[c];
         start     = st_start[c];
         bit_valid = st_valid[c];
         bit_in    = st_bit[c];
         bit_last  = st_last[c];
         running   = 1'b1;
      end
      @(posedge clk);
      running = 1'b0;
      for (int f = 0; f < 3; f++) decode(f, T6 + 600*f, (rur[f] >= 0) ? rur[f] : 64);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
